down_counter: RTL and testbench
===============================

# down_counter

Loadable down-counter/timer, the counterpart of the team's free-running up counter. Accepts a start value over a valid/ready load handshake, decrements on enabled cycles, and flags terminal count with a single-cycle pulse. Supports one-shot and auto-reload modes. Sits beside the up counter as the timeout/interval source for control logic.

## Interface
- WIDTH, 4: counter and load-value width in bits (≥2).

- clk  in  1  rising-edge clock; all state changes on this edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  load request; `load_value` and `load_auto` qualified by it.
- load_ready  out  1  block can accept a load (high in IDLE and DONE).
- load_value  in  WIDTH  start value N; the period is N+1 enabled cycles.
- load_auto  in  1  1 = auto-reload mode, 0 = one-shot; latched on load.
- enable  in  1  count gate; a RUN cycle without `enable` holds all state.
- abort  in  1  cancels a running count.
- count  out  WIDTH  current count value (registered).
- busy  out  1  high in RUN.
- tc  out  1  one-cycle terminal-count pulse (registered).
- done  out  1  high in DONE (one-shot finished) until the next load.

## Operation
- States: IDLE, RUN, DONE.
- Reset (asynchronous, `reset_n`=0): state=IDLE, count=0, reload register=0, auto=0, tc=0, busy=0, done=0, load_ready=1.
- Load accept = `load_valid` & `load_ready`, from IDLE or DONE.
  - count←load_value, reload←load_value, auto←load_auto, state→RUN.
  - done is cleared.
- RUN with `abort`=1 (highest priority): state→IDLE, count←0, tc stays 0. Applies even if `enable`=1 or count=0.
- RUN with `enable`=1, count≠0: count←count−1.
- RUN with `enable`=1, count=0: tc←1 for one cycle.
  - auto=1: count←reload, stay in RUN.
  - auto=0: state→DONE, count stays 0.
- RUN with `enable`=0: hold all state.
- Loading N=0 is legal: tc fires on the first enabled RUN cycle. With auto=1 and reload=0, tc fires on every enabled cycle.
- `abort` in IDLE or DONE has no effect. A load in the same cycle as abort is taken normally.
- `load_valid` during RUN is ignored (`load_ready`=0). The requester must hold it until accepted.
- Arithmetic is unsigned, modulo 2^WIDTH. No wrap below 0 ever occurs, because 0 leads to reload or stop.

## Timing
- Load accepted at edge k: busy=1 and count=N visible after edge k. `load_ready`=0 from edge k.
- With `enable` held high:
  - count=0 is seen in the cycle after edge k+N.
  - tc=1, and (one-shot) busy=0 / done=1 / load_ready=1, from edge k+N+1 for one cycle (tc only).
- Auto-reload, `enable` high: tc pulses every N+1 cycles, first at edge k+N+1. count sequence: N, N−1, …, 0, N, …
- Gaps in `enable` stretch the period by exactly the number of disabled cycles.
- Abort at edge j: busy=0 and count=0 after edge j. A pending terminal count at that edge is suppressed.
- Reset asserted mid-count: outputs go to reset values immediately (asynchronous). After deassertion the block is in IDLE and needs a new load.
- All outputs are registered except `load_ready` and `busy`, which are state decodes.

## Structure
- Package `down_counter_pkg`: state typedef/enum (IDLE, RUN, DONE) and the default WIDTH constant.
- Single module `down_counter`; no sub-module.
- Internal registers: state, count, reload, auto, tc.

## Test plan
- Reset, then load N=3, one-shot, `enable` high:
  - count 3,2,1,0.
  - tc=1 for exactly one cycle 4 cycles after accept.
  - done=1, busy=0, count=0.
- Load N=2, auto, `enable` high for 10 cycles: tc pulses on cycles 3, 6 and 9 after accept; count is 2,1,0,2,1,0…
- Load N=4, toggle `enable` 1,0,1,0,…: count changes only on enabled cycles; tc arrives after 5 enabled cycles.
- Load N=5, assert abort when count=2:
  - next cycle state IDLE, count=0, tc never fires.
  - A new load of N=1 is accepted immediately.
- Load N=0, auto, `enable` high: tc=1 every cycle; `load_valid` during RUN is not accepted (`load_ready`=0).
- Drop `reset_n` at count=3 between clock edges: count, busy, tc and done go to 0 immediately; after release, block is IDLE with `load_ready`=1.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down-counter/timer.
package down_counter_pkg;

    localparam int DC_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dc_state_e;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// Loadable down-counter with one-shot / auto-reload modes and a registered
// single-cycle terminal-count pulse.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load_auto,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    dc_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             auto_q, auto_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    // Next-state logic: abort beats counting; zero either reloads or stops.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        auto_d   = auto_q;
        tc_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_valid) begin
                    count_d  = load_value;
                    reload_d = load_value;
                    auto_d   = load_auto;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = state_q;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    count_d = ZERO_C;
                    state_d = ST_IDLE;
                end else if (enable) begin
                    if (count_q != ZERO_C) begin
                        count_d = count_q - ONE_C;
                    end else begin
                        tc_d = 1'b1;
                        if (auto_q) begin
                            count_d = reload_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = ZERO_C;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO_C;
            reload_q <= ZERO_C;
            auto_q   <= 1'b0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            auto_q   <= auto_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy       = (state_q == ST_RUN);
    assign count      = count_q;
    assign tc         = tc_q;
    assign done       = done_q;

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (WIDTH=4).
module tb_down_counter;

    logic       clk;
    logic       reset_n;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_value;
    logic       load_auto;
    logic       enable;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    down_counter #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .load_auto  (load_auto),
        .enable     (enable),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] c, input logic b,
                             input logic t, input logic d, input logic r);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".tc"}, 32'(tc), 32'(t));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".load_ready"}, 32'(load_ready), 32'(r));
    endtask

    initial begin
        int e;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_value = 4'd0;
        load_auto  = 1'b0;
        enable     = 1'b0;
        abort      = 1'b0;
        #12;
        check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        tick();
        check_all("idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // One-shot N=3
        load_valid = 1'b1; load_value = 4'd3; load_auto = 1'b0; enable = 1'b1;
        tick();
        load_valid = 1'b0;
        check_all("os_k", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_all("os_k1", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_all("os_k2", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_all("os_k3", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_all("os_k4", 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(); check_all("os_k5", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Auto-reload N=2, loaded from DONE
        load_valid = 1'b1; load_value = 4'd2; load_auto = 1'b1;
        tick();
        load_valid = 1'b0;
        check_all("ar_k", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_all($sformatf("ar_%0d", i),
                      (i % 3 == 0) ? 4'd2 : 4'(2 - (i % 3)),
                      1'b1, (i % 3 == 0), 1'b0, 1'b0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_all("ar_abort", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // One-shot N=4 with enable toggling 1,0,1,0,...
        load_valid = 1'b1; load_value = 4'd4; load_auto = 1'b0;
        tick();
        load_valid = 1'b0;
        check_all("gap_k", 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        e = 0;
        for (int i = 0; i < 10; i++) begin
            enable = (i % 2 == 0);
            tick();
            if (enable) e++;
            check_all($sformatf("gap_%0d", i),
                      (e >= 4) ? 4'd0 : 4'(4 - e),
                      (e < 5), (enable && e == 5), (e >= 5), (e >= 5));
        end
        enable = 1'b1;

        // N=5 aborted at count=2, then load N=1 with abort held
        load_valid = 1'b1; load_value = 4'd5;
        tick();
        load_valid = 1'b0;
        check_all("ab_k", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        check_all("ab_2", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        check_all("ab_j", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("ab_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b1; load_value = 4'd1;
        tick();
        load_valid = 1'b0; abort = 1'b0;
        check_all("ab_reload", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_all("ab_r1", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_all("ab_r2", 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // N=0 auto: tc every cycle, loads during RUN ignored
        load_valid = 1'b1; load_value = 4'd0; load_auto = 1'b1;
        tick();
        load_value = 4'd3;
        check_all("z_k", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_all($sformatf("z_%0d", i), 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        load_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_all("z_abort", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-count
        load_valid = 1'b1; load_value = 4'd5; load_auto = 1'b0;
        tick();
        load_valid = 1'b0;
        tick(); tick();
        check_all("rst_pre", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_all("rst_async", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 reset_n = 1'b1;
        tick();
        check_all("rst_after", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_down_counter
